// File: rtl/memory_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage: memory op/size encodings,
// the EX/MEM register layout and the MEM-stage state machine encoding.
package memory_access_stage_pkg;

    localparam int unsigned ADDR_WIDTH = 4;
    localparam int unsigned WORD       = 32;
    localparam int unsigned BYTE_LANES = 4;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'd0,
        MEM_LOAD  = 2'd1,
        MEM_STORE = 2'd2
    } mem_op_sig;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_sig;

    typedef enum logic {
        REG_WRITE_DIS = 1'b0,
        REG_WRITE_EN  = 1'b1
    } reg_file_write_sig;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BUSY      = 2'd1,
        LOAD_DONE = 2'd2
    } mem_stage_state;

    // All-zero value is the reset/bubble state (invalid, MEM_NONE, write disabled).
    typedef struct packed {
        logic                  valid;
        mem_op_sig             op;
        mem_size_sig           size;
        logic                  sign_extend;
        reg_file_write_sig     reg_write_en;
        logic [ADDR_WIDTH-1:0] reg_dest;
        logic [WORD-1:0]       alu_result;
        logic [WORD-1:0]       store_data;
    } ex_mem_reg_t;

endpackage

// File: rtl/memory_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage (master) and the data memory (slave).
interface memory_access_stage_if;
    import memory_access_stage_pkg::*;

    logic                  req;
    logic                  we;
    logic [WORD-1:0]       addr;
    logic [WORD-1:0]       wdata;
    logic [BYTE_LANES-1:0] byte_en;
    logic [WORD-1:0]       rdata;
    logic                  ack;

    modport master (
        output req, we, addr, wdata, byte_en,
        input  rdata, ack
    );

    modport slave (
        input  req, we, addr, wdata, byte_en,
        output rdata, ack
    );

endinterface

// File: rtl/memory_access_stage_load_store_aligner.sv
// Combinational lane steering: byte enables, store-data replication, load extract and
// extend, and alignment check for the access held in the MEM stage.
module memory_access_stage_load_store_aligner
    import memory_access_stage_pkg::*;
(
    input  mem_size_sig           size_i,
    input  logic [1:0]            addr_lo_i,
    input  logic                  sign_extend_i,
    input  logic [WORD-1:0]       store_data_i,
    input  logic [WORD-1:0]       rdata_i,
    output logic [BYTE_LANES-1:0] byte_en_o,
    output logic [WORD-1:0]       wdata_o,
    output logic [WORD-1:0]       load_data_o,
    output logic                  misalign_o
);

    logic [WORD-1:0] shifted;

    always_comb begin
        shifted     = rdata_i >> {addr_lo_i, 3'b000};
        byte_en_o   = 4'b1111;
        wdata_o     = store_data_i;
        load_data_o = shifted;
        misalign_o  = 1'b0;
        case (size_i)
            SIZE_BYTE: begin
                byte_en_o   = 4'b0001 << addr_lo_i;
                wdata_o     = {4{store_data_i[7:0]}};
                load_data_o = {{(WORD-8){sign_extend_i & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                byte_en_o   = 4'b0011 << {addr_lo_i[1], 1'b0};
                wdata_o     = {2{store_data_i[15:0]}};
                load_data_o = {{(WORD-16){sign_extend_i & shifted[15]}}, shifted[15:0]};
                misalign_o  = addr_lo_i[0];
            end
            default: begin
                misalign_o = |addr_lo_i;
            end
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: EX/MEM register, req/ack data-memory access FSM and the
// destination/write-enable/result outputs feeding forwarding and writeback.
module memory_access_stage
    import memory_access_stage_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  is_valid_i,
    input  logic                  flush_i,
    input  mem_op_sig             mem_op_i,
    input  mem_size_sig           mem_size_i,
    input  logic                  sign_extend_i,
    input  reg_file_write_sig     reg_write_en_i,
    input  logic [ADDR_WIDTH-1:0] reg_dest_i,
    input  logic [WORD-1:0]       alu_result_i,
    input  logic [WORD-1:0]       store_data_i,
    memory_access_stage_if.master dmem,
    output logic                  stall_o,
    output logic                  misalign_fault_o,
    output logic                  is_valid_o,
    output reg_file_write_sig     reg_write_en_o,
    output logic [ADDR_WIDTH-1:0] reg_dest_o,
    output logic [WORD-1:0]       result_o
);

    ex_mem_reg_t           stage_q, stage_d;
    mem_stage_state        state_q, state_d;
    logic [WORD-1:0]       rdata_q, rdata_d;

    logic                  misalign_raw, misalign, mem_active, req, stall, is_valid;
    logic [BYTE_LANES-1:0] byte_en;
    logic [WORD-1:0]       wdata, load_data;

    memory_access_stage_load_store_aligner u_aligner (
        .size_i        (stage_q.size),
        .addr_lo_i     (stage_q.alu_result[1:0]),
        .sign_extend_i (stage_q.sign_extend),
        .store_data_i  (stage_q.store_data),
        .rdata_i       (rdata_q),
        .byte_en_o     (byte_en),
        .wdata_o       (wdata),
        .load_data_o   (load_data),
        .misalign_o    (misalign_raw)
    );

    // Stage register: a flush only squashes the instruction being captured.
    always_comb begin
        stage_d = stage_q;
        if (!stall) begin
            stage_d.valid        = is_valid_i & ~flush_i;
            stage_d.op           = mem_op_i;
            stage_d.size         = mem_size_i;
            stage_d.sign_extend  = sign_extend_i;
            stage_d.reg_write_en = reg_write_en_i;
            stage_d.reg_dest     = reg_dest_i;
            stage_d.alu_result   = alu_result_i;
            stage_d.store_data   = store_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            stage_q <= '0;
            state_q <= IDLE;
            rdata_q <= '0;
        end else begin
            stage_q <= stage_d;
            state_q <= state_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        unique case (state_q)
            IDLE, BUSY: begin
                if (req && !dmem.ack) begin
                    state_d = BUSY;
                end else if (req && stage_q.op == MEM_LOAD) begin
                    state_d = LOAD_DONE;
                    rdata_d = dmem.rdata;
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD_DONE: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        misalign   = misalign_raw & (stage_q.op != MEM_NONE);
        mem_active = stage_q.valid & (stage_q.op != MEM_NONE) & ~misalign;
        req        = mem_active & (state_q != LOAD_DONE);
        // A store acked this cycle retires now, so the pipeline may move.
        stall      = req & ~(dmem.ack & (stage_q.op == MEM_STORE));
        is_valid   = stage_q.valid & ~misalign;
    end

    assign dmem.req         = req;
    assign dmem.we          = req & (stage_q.op == MEM_STORE);
    assign dmem.addr        = {stage_q.alu_result[WORD-1:2], 2'b00};
    assign dmem.wdata       = wdata;
    assign dmem.byte_en     = req ? byte_en : '0;

    assign stall_o          = stall;
    assign misalign_fault_o = stage_q.valid & misalign;
    assign is_valid_o       = is_valid;
    assign reg_write_en_o   = is_valid ? stage_q.reg_write_en : REG_WRITE_DIS;
    assign reg_dest_o       = stage_q.reg_dest;
    assign result_o         = (state_q == LOAD_DONE) ? load_data : stage_q.alu_result;

endmodule
